flit_out_scheduler: RTL
=======================

FLIT_OUT_SCHEDULER -- requirements
Module: flit_out_scheduler

Interface
REQ-001 SHALL have parameter DEPTH, default 4, per-source FIFO depth; power of two, 2..16.
REQ-002 SHALL have parameter STARVE_LIMIT, default 4, maximum consecutive normal-flit wait cycles under system priority; 1..15.
REQ-003 SHALL have port nocclk, input, 1 bit, the only clock.
REQ-004 SHALL have port rst, input, 1 bit, asynchronous active-high reset.
REQ-005 SHALL have port in_sys_flit_valid, input, 1 bit, system flit present.
REQ-006 SHALL have port in_sys_flit, input, types::flit_t, system flit.
REQ-007 SHALL have port out_sys_ready, output, 1 bit, system FIFO can accept.
REQ-008 SHALL have port in_normal_flit_valid, input, 1 bit, normal flit present.
REQ-009 SHALL have port in_normal_flit, input, types::flit_t, normal flit.
REQ-010 SHALL have port out_normal_ready, output, 1 bit, normal FIFO can accept.
REQ-011 SHALL have port out_flit_valid, output, 1 bit, flit offered to link.
REQ-012 SHALL have port out_flit, output, types::flit_t, offered flit.
REQ-013 SHALL have port out_flit_is_system, output, 1 bit, offered flit came from system FIFO.
REQ-014 SHALL have port in_flit_ready, input, 1 bit, link accepts offered flit.
REQ-015 SHALL have ports out_sys_count and out_normal_count, output, $clog2(DEPTH+1) bits each, FIFO occupancy.

Function
REQ-016 SHALL push a source FIFO on a cycle where its valid and ready are both high.
REQ-017 SHALL drive out_*_ready = !full from registered occupancy only; no same-cycle pass-through when full, even if that FIFO is popped.
REQ-018 SHALL make a pushed flit visible on out_flit no earlier than the cycle after the push (latency 1 when empty and granted).
REQ-019 SHALL drive out_flit_valid high whenever the granted FIFO is non-empty; out_flit is that FIFO's head.
REQ-020 SHALL pop the granted FIFO on a cycle where out_flit_valid and in_flit_ready are both high.
REQ-021 SHALL hold grant, out_flit and out_flit_is_system stable while out_flit_valid is high and in_flit_ready is low (grant lock).
REQ-022 SHALL, when unlocked, use states SYS_PRIO and NORMAL_FORCED; in SYS_PRIO grant system if non-empty, else normal.
REQ-023 SHALL increment a starvation counter each cycle the normal FIFO is non-empty and no normal pop occurs, saturating at STARVE_LIMIT.
REQ-024 SHALL enter NORMAL_FORCED when the counter reaches STARVE_LIMIT; in NORMAL_FORCED grant normal at the next unlocked decision.
REQ-025 SHALL clear the counter and return to SYS_PRIO on every normal pop.
REQ-026 SHALL clear the counter when the normal FIFO is empty.
REQ-027 SHALL wrap FIFO read/write pointers modulo DEPTH; occupancy is unchanged on simultaneous push and pop of the same FIFO.
REQ-028 SHALL never pop an empty FIFO and never push a full FIFO; such attempts have no effect.

Reset
REQ-029 SHALL, while rst is high, asynchronously clear both FIFOs' pointers and occupancy, the counter and the grant lock, and set state SYS_PRIO.
REQ-030 SHALL, during reset, drive out_flit_valid=0, out_flit_is_system=0, out_sys_ready=1, out_normal_ready=1, both counts=0 and out_flit='0.
REQ-031 SHALL discard in-flight flits on reset mid-operation; no flit is offered in the first cycle after deassertion.

Structure
REQ-032 SHALL place the scheduler state enum and the STARVE_LIMIT default in a shared package; flit_t is taken from the existing types package.
REQ-033 SHALL instantiate sub-module flit_fifo (parameter DEPTH, types::flit_t payload) twice, once per source.

Verification
REQ-034 SHALL test an idle system push: one system flit 0xA5 with in_flit_ready=1 -> out_flit=0xA5 and is_system=1 in the next cycle, then valid drops.
REQ-035 SHALL test backpressure: with in_flit_ready=0, push 4 system flits -> count=4, out_sys_ready=0, out_flit held at the first flit; release -> 4 flits in order.
REQ-036 SHALL test starvation: stream system flits continuously, 1 normal flit pending, STARVE_LIMIT=4 -> the normal flit is accepted within 6 cycles of its push.
REQ-037 SHALL test a lock hold: normal flit offered, system flit arrives while in_flit_ready=0 -> out_flit stays the normal flit until accepted.
REQ-038 SHALL test a full FIFO with simultaneous pop: normal FIFO full and popped with a push attempted -> push rejected (ready=0), count 4 -> 3.
REQ-039 SHALL test reset mid-stream: rst asserted with 3 flits queued -> counts=0 and valid=0 immediately; no stale flit appears after release.

Source files
------------

// File: rtl/flit_out_scheduler_pkg.sv
// Scheduler state encoding and default starvation parameters for flit_out_scheduler.
package flit_out_scheduler_pkg;

  // SYS_PRIO: system flits win; NORMAL_FORCED: the starved normal flit goes next.
  typedef enum logic {
    SYS_PRIO      = 1'b0,
    NORMAL_FORCED = 1'b1
  } sched_state_e;

  localparam int unsigned STARVE_LIMIT_DEF = 4;
  // Wide enough for the largest allowed STARVE_LIMIT (15).
  localparam int unsigned STARVE_CNT_W     = 4;

endpackage

// File: rtl/types.sv
// Shared link-level types used by the NoC blocks.
package types;

  localparam int unsigned FLIT_W = 8;

  typedef logic [FLIT_W-1:0] flit_t;

endpackage

// File: rtl/flit_fifo.sv
// Single-clock flit FIFO with registered occupancy; ready depends only on registered state.
// Ports:
//   clk_i, rst_i           : clock, asynchronous active-high reset
//   push_valid_i/_ready_o  : write handshake, push_flit_i is the written flit
//   pop_i                  : pop request (ignored when empty)
//   head_o, nonempty_o     : oldest entry and its validity
//   count_o                : occupancy 0..DEPTH
module flit_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           push_valid_i,
  output logic                           push_ready_o,
  input  types::flit_t                   push_flit_i,
  input  logic                           pop_i,
  output types::flit_t                   head_o,
  output logic                           nonempty_o,
  output logic [$clog2(DEPTH+1)-1:0]     count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full;
  logic             do_push;
  logic             do_pop;
  types::flit_t     mem_q [DEPTH];

  // Handshake qualification and pointer/occupancy update; DEPTH is a power of two so pointers wrap naturally.
  always_comb begin
    full     = (count_q == CNT_W'(DEPTH));
    do_push  = push_valid_i && !full;
    do_pop   = pop_i && (count_q != '0);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
    else if (!do_push && do_pop) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only observed once occupancy says so.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_flit_i;
  end

  assign push_ready_o = !full;
  assign head_o       = mem_q[rd_ptr_q];
  assign nonempty_o   = (count_q != '0);
  assign count_o      = count_q;

endmodule

// File: rtl/flit_out_scheduler.sv
// Two-source link scheduler: system flits have priority, normal flits are forced through
// after STARVE_LIMIT wait cycles, and the offered flit is locked until the link accepts it.
// Ports:
//   nocclk, rst                              : clock, asynchronous active-high reset
//   in_sys_flit_valid/in_sys_flit/out_sys_ready       : system source push interface
//   in_normal_flit_valid/in_normal_flit/out_normal_ready : normal source push interface
//   out_flit_valid/out_flit/out_flit_is_system/in_flit_ready : link-side offer handshake
//   out_sys_count, out_normal_count          : FIFO occupancies
module flit_out_scheduler
  import flit_out_scheduler_pkg::*;
#(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic                       nocclk,
  input  logic                       rst,
  input  logic                       in_sys_flit_valid,
  input  types::flit_t               in_sys_flit,
  output logic                       out_sys_ready,
  input  logic                       in_normal_flit_valid,
  input  types::flit_t               in_normal_flit,
  output logic                       out_normal_ready,
  output logic                       out_flit_valid,
  output types::flit_t               out_flit,
  output logic                       out_flit_is_system,
  input  logic                       in_flit_ready,
  output logic [$clog2(DEPTH+1)-1:0] out_sys_count,
  output logic [$clog2(DEPTH+1)-1:0] out_normal_count
);

  sched_state_e              state_q, state_d;
  logic [STARVE_CNT_W-1:0]   starve_cnt_q, starve_cnt_d;
  logic                      lock_q, lock_d;
  logic                      lock_sys_q, lock_sys_d;

  logic                      sys_nonempty, norm_nonempty;
  types::flit_t              sys_head, norm_head;
  logic                      grant_sys;
  logic                      flit_valid;
  logic                      sys_pop, norm_pop;

  flit_fifo #(.DEPTH(DEPTH)) u_sys_fifo (
    .clk_i        (nocclk),
    .rst_i        (rst),
    .push_valid_i (in_sys_flit_valid),
    .push_ready_o (out_sys_ready),
    .push_flit_i  (in_sys_flit),
    .pop_i        (sys_pop),
    .head_o       (sys_head),
    .nonempty_o   (sys_nonempty),
    .count_o      (out_sys_count)
  );

  flit_fifo #(.DEPTH(DEPTH)) u_normal_fifo (
    .clk_i        (nocclk),
    .rst_i        (rst),
    .push_valid_i (in_normal_flit_valid),
    .push_ready_o (out_normal_ready),
    .push_flit_i  (in_normal_flit),
    .pop_i        (norm_pop),
    .head_o       (norm_head),
    .nonempty_o   (norm_nonempty),
    .count_o      (out_normal_count)
  );

  // Grant selection, pop generation, grant lock and starvation tracking.
  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    lock_d       = 1'b0;
    lock_sys_d   = lock_sys_q;
    grant_sys    = 1'b0;
    flit_valid   = 1'b0;
    sys_pop      = 1'b0;
    norm_pop     = 1'b0;

    // A locked FIFO stays non-empty until popped, so the offer is stable while locked.
    if (lock_q) begin
      grant_sys = lock_sys_q;
    end else if ((state_q == NORMAL_FORCED) && norm_nonempty) begin
      grant_sys = 1'b0;
    end else begin
      grant_sys = sys_nonempty;
    end

    flit_valid = grant_sys ? sys_nonempty : norm_nonempty;
    sys_pop    = flit_valid && in_flit_ready && grant_sys;
    norm_pop   = flit_valid && in_flit_ready && !grant_sys;
    lock_d     = flit_valid && !in_flit_ready;
    lock_sys_d = grant_sys;

    if (norm_pop) begin
      starve_cnt_d = '0;
      state_d      = SYS_PRIO;
    end else if (!norm_nonempty) begin
      starve_cnt_d = '0;
    end else begin
      if (starve_cnt_q < STARVE_CNT_W'(STARVE_LIMIT)) begin
        starve_cnt_d = starve_cnt_q + STARVE_CNT_W'(1);
      end
      if (starve_cnt_d == STARVE_CNT_W'(STARVE_LIMIT)) begin
        state_d = NORMAL_FORCED;
      end
    end
  end

  always_ff @(posedge nocclk or posedge rst) begin
    if (rst) begin
      state_q      <= SYS_PRIO;
      starve_cnt_q <= '0;
      lock_q       <= 1'b0;
      lock_sys_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      lock_q       <= lock_d;
      lock_sys_q   <= lock_sys_d;
    end
  end

  // Offered flit is forced to zero when nothing is offered, which also covers reset.
  assign out_flit_valid     = flit_valid;
  assign out_flit           = flit_valid ? (grant_sys ? sys_head : norm_head) : '0;
  assign out_flit_is_system = flit_valid && grant_sys;

endmodule
